ro_freq_meter: RTL



---
 rtl/ro_meter_pkg.sv | 15 +
 rtl/ro_edge_sync.sv | 28 ++
 rtl/ro_freq_meter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ro_meter_pkg.sv
// Shared types and sizes for the ring-oscillator frequency meter.
package ro_meter_pkg;

    localparam int NUM_RO = 5;
    localparam int TAP_W  = 3;

    // Prefixed so the SETTLE state cannot collide with the SETTLE parameter of the top level.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_DONE
    } meter_state_e;

endpackage

// File: rtl/ro_edge_sync.sv
// Brings one asynchronous oscillator tap into the clock domain through two flops,
// then flags each rising edge for one cycle using a third history flop.
module ro_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/ro_freq_meter.sv
// Ring-oscillator measurement engine: settles the oscillator, counts rising edges of one
// synchronised tap over a programmed window, and returns the count on a valid/ready port.
// Optional RO_METER_SATURATE_EN: the counter saturates and reports overflow instead of wrapping.
module ro_freq_meter
    import ro_meter_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int WIN_W  = 16,
    parameter int SETTLE = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [4:0]       cmd_cfg,
    input  logic [TAP_W-1:0] cmd_tap,
    input  logic [WIN_W-1:0] cmd_window,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_count,
    output logic             res_overflow,
    output logic [4:0]       ro_sel,
    output logic             ro_start,
    input  logic [4:0]       ro_x
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    meter_state_e      state_q, state_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [TAP_W-1:0]  tap_q, tap_d;
    logic [4:0]        sel_q, sel_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;

    logic [NUM_RO-1:0]     rise;
    logic [2**TAP_W-1:0]   rise_pad;
    logic                  tap_rise;
    logic                  accept;

    for (genvar i = 0; i < NUM_RO; i++) begin : g_sync
        ro_edge_sync u_sync (
            .clk_i  (wb_clk_i),
            .rst_ni (wb_rst_ni),
            .async_i(ro_x[i]),
            .rise_o (rise[i])
        );
    end

    // Unused tap codes select zero-padding, so they never count anything.
    assign rise_pad = {{(2**TAP_W-NUM_RO){1'b0}}, rise};
    assign tap_rise = rise_pad[tap_q];
    assign accept   = (state_q == ST_IDLE) && cmd_valid;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cmd_valid) state_d = ST_SETTLE;
            ST_SETTLE: if (settle_q == '0) state_d = (win_q == '0) ? ST_DONE : ST_GATE;
            ST_GATE:   if (win_q == WIN_W'(1)) state_d = ST_DONE;
            ST_DONE:   if (res_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        res_valid = (state_q == ST_DONE);
        ro_start  = (state_q == ST_SETTLE) || (state_q == ST_GATE);
    end

    always_comb begin
        settle_d = settle_q;
        win_d    = win_q;
        tap_d    = tap_q;
        sel_d    = sel_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (accept) begin
            settle_d = SET_W'(SETTLE - 1);
            win_d    = cmd_window;
            tap_d    = cmd_tap;
            sel_d    = cmd_cfg;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else if (state_q == ST_SETTLE) begin
            if (settle_q != '0) settle_d = settle_q - SET_W'(1);
        end else if (state_q == ST_GATE) begin
            win_d = win_q - WIN_W'(1);
            if (tap_rise) begin
`ifdef RO_METER_SATURATE_EN
                if (count_q == '1) ovf_d = 1'b1;
                else               count_d = count_q + CNT_W'(1);
`else
                count_d = count_q + CNT_W'(1);
`endif
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            settle_q <= '0;
            win_q    <= '0;
            tap_q    <= '0;
            sel_q    <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            settle_q <= settle_d;
            win_q    <= win_d;
            tap_q    <= tap_d;
            sel_q    <= sel_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ro_sel       = sel_q;
    assign res_count    = count_q;
    assign res_overflow = ovf_q;

endmodule
